fetch_ifid_stage: RTL and testbench
===================================

// Module: fetch_ifid_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register of the 5-stage RV32I core. Holds the PC,
//  fetches from instruction memory over a valid/ready request / valid response port,
//  and loads the IF/ID register that feeds decode. Obeys PCWrite/IFIDWrite from the
//  load-use hazard unit, and the branch/jump flush from EX.
// PARAMETERS
//  XLEN     32            datapath / PC width
//  RESET_PC 32'h0000_0000 first fetch address after reset
//  NOP      32'h0000_0013 bubble encoding (addi x0,x0,0)
// PORTS
//  clk            in  1     single clock, rising edge
//  rst_n          in  1     asynchronous, active-low reset
//  pc_write       in  1     0 = do not issue a new fetch or advance PC (load-use stall)
//  ifid_write     in  1     0 = IF/ID holds its contents (load-use stall)
//  flush          in  1     taken branch/jump resolved in EX
//  redirect_pc    in  XLEN  target PC, valid with flush
//  imem_req_valid out 1     fetch request
//  imem_req_ready in  1     memory accepts request
//  imem_req_addr  out XLEN  fetch address (word aligned)
//  imem_rsp_valid in  1     instruction returned (>=1 cycle after accept, in order)
//  imem_rsp_data  in  32    instruction word
//  ifid_valid     out 1     IF/ID holds a real instruction
//  ifid_pc        out XLEN  PC of the IF/ID instruction
//  ifid_instr     out 32    IF/ID instruction (NOP when invalid)
//  ifid_rs1       out 5     ifid_instr[19:15], to hazard unit
//  ifid_rs2       out 5     ifid_instr[24:20], to hazard unit
// BEHAVIOUR
//  - Reset (async, any state): pc_q=RESET_PC, state=REQ, ifid_valid=0, ifid_pc=0,
//    ifid_instr=NOP, imem_req_valid=0 while rst_n=0. Responses arriving in REQ are ignored.
//  - At most one outstanding request. req_pc latched on accept; pc_q <= pc_q+4 (mod 2^XLEN).
//  - FSM:
//    REQ : imem_req_valid = pc_write & ~flush; addr=pc_q. Accept -> WAIT.
//    WAIT: on rsp: if ifid_write, load IF/ID {1,req_pc,rsp_data} -> REQ;
//          else capture into hold reg -> HOLD.
//    HOLD: when ifid_write, load IF/ID from hold reg -> REQ.
//    DROP: wrong-path request in flight; on rsp discard data -> REQ.
//  - IF/ID update when ifid_write=1 and no new instruction is available this cycle:
//    load bubble (valid=0, instr=NOP, pc unchanged). ifid_write=0: all IF/ID bits hold.
//  - flush (highest priority, overrides ifid_write=0 and pc_write=0):
//    pc_q <= redirect_pc; IF/ID <= bubble; hold reg discarded; imem_req_valid forced 0.
//    Next state: REQ if idle, in HOLD, or rsp arrives same cycle (rsp discarded);
//    DROP if in WAIT/DROP without rsp this cycle. Flush in DROP with rsp -> REQ.
//  - Latency: accept at cycle N, rsp at N+k -> IF/ID valid at N+k+1. Peak 1 instr / 2 cycles
//    with k=1.
//  - imem_req_addr stable while imem_req_valid=1 and not accepted (unless flush).
//  - redirect_pc[1:0] ignored (forced 0).
// TESTING
//  1 Reset release, ready=1, rsp 1 cycle later: addrs 0x0,0x4,0x8; ifid_pc follows, valid=1.
//  2 Load-use: pc_write=ifid_write=0 for 1 cycle while instr@0x8 held in IF/ID -> IF/ID
//    unchanged, no new request, then 0xC fetched next.
//  3 ifid_write=0 when rsp for 0xC arrives -> HOLD; release -> IF/ID = 0xC instr, no refetch.
//  4 flush redirect_pc=0x100 while WAIT -> DROP; stale rsp discarded; next req 0x100;
//    IF/ID bubble (NOP).
//  5 flush in same cycle as rsp, with ifid_write=0 -> IF/ID bubble, rsp dropped, req 0x100.
//  6 rst_n low mid-WAIT -> outputs at reset values immediately; late rsp ignored;
//    refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_ifid_stage.sv
// IF stage and IF/ID pipeline register: PC, single-outstanding instruction fetch,
// load-use stall handling and EX-resolved flush/redirect.
module fetch_ifid_stage #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0,
  parameter logic [31:0]          NOP      = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            ifid_write,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic [4:0]      ifid_rs1,
  output logic [4:0]      ifid_rs2
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_pc;
  logic [31:0]     r_hold;
  logic            r_ifid_valid;
  logic [XLEN-1:0] r_ifid_pc;
  logic [31:0]     r_ifid_instr;

  logic            w_req_valid;
  logic            w_accept;
  logic            w_new_avail;
  logic [31:0]     w_new_instr;
  logic [XLEN-1:0] w_redirect;

  // Request is held off during reset, stalls and flushes.
  assign w_req_valid = rst_n & (r_state == S_REQ) & pc_write & ~flush;
  assign w_accept    = w_req_valid & imem_req_ready;
  assign w_new_avail = ((r_state == S_WAIT) & imem_rsp_valid) | (r_state == S_HOLD);
  assign w_new_instr = (r_state == S_HOLD) ? r_hold : imem_rsp_data;
  assign w_redirect  = redirect_pc & ALIGN_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC & ALIGN_MASK;
      r_req_pc     <= '0;
      r_hold       <= NOP;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP;
    end else if (flush) begin
      // An in-flight request whose response has not yet arrived must be drained.
      r_pc         <= w_redirect;
      r_hold       <= NOP;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= NOP;
      if (((r_state == S_WAIT) || (r_state == S_DROP)) && !imem_rsp_valid) begin
        r_state <= S_DROP;
      end else begin
        r_state <= S_REQ;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_accept) begin
            r_req_pc <= r_pc;
            r_pc     <= r_pc + PC_STEP;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (ifid_write) begin
              r_state <= S_REQ;
            end else begin
              r_hold  <= imem_rsp_data;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (ifid_write) begin
            r_state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase

      // IF/ID: load new instruction, else insert a bubble keeping the PC.
      if (ifid_write) begin
        if (w_new_avail) begin
          r_ifid_valid <= 1'b1;
          r_ifid_pc    <= r_req_pc;
          r_ifid_instr <= w_new_instr;
        end else begin
          r_ifid_valid <= 1'b0;
          r_ifid_instr <= NOP;
        end
      end
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;
  assign ifid_valid     = r_ifid_valid;
  assign ifid_pc        = r_ifid_pc;
  assign ifid_instr     = r_ifid_instr;
  assign ifid_rs1       = r_ifid_instr[19:15];
  assign ifid_rs2       = r_ifid_instr[24:20];

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Directed bench for fetch_ifid_stage: fetch, stalls, hold, flushes and async reset.
module tb_fetch_ifid_stage;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk;
  logic            rst_n;
  logic            pc_write;
  logic            ifid_write;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            ifid_valid;
  logic [XLEN-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic [4:0]      ifid_rs1;
  logic [4:0]      ifid_rs2;

  int n_checks = 0;
  int n_errors = 0;

  fetch_ifid_stage #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000),
    .NOP      (NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_rs1       (ifid_rs1),
    .ifid_rs2       (ifid_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    chk({tag, "_valid"}, 32'(ifid_valid), 32'(v));
    chk({tag, "_pc"}, ifid_pc, pc);
    chk({tag, "_instr"}, ifid_instr, instr);
  endtask

  initial begin
    rst_n          = 1'b0;
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    flush          = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;

    tick();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk_ifid("rst", 1'b0, 32'h0, NOP);
    tick();

    // Test 1: back-to-back fetch with one-cycle responses.
    rst_n = 1'b1;
    #1;
    chk("t1_req0_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_req0_addr", imem_req_addr, 32'h0);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0100_0033;
    #1;
    chk("t1_wait_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk_ifid("t1_i0", 1'b1, 32'h0, 32'h0100_0033);
    chk("t1_req1_addr", imem_req_addr, 32'h4);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0504_0433;
    #1;
    chk_ifid("t1_bubble", 1'b0, 32'h0, NOP);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk_ifid("t1_i1", 1'b1, 32'h4, 32'h0504_0433);
    chk("t1_req2_addr", imem_req_addr, 32'h8);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0908_0833;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk_ifid("t1_i2", 1'b1, 32'h8, 32'h0908_0833);
    chk("t1_rs1", 32'(ifid_rs1), 32'd16);
    chk("t1_rs2", 32'(ifid_rs2), 32'd16);

    // Test 2: load-use stall for one cycle.
    pc_write = 1'b0; ifid_write = 1'b0;
    #1;
    chk("t2_stall_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    pc_write = 1'b1; ifid_write = 1'b1;
    #1;
    chk_ifid("t2_held", 1'b1, 32'h8, 32'h0908_0833);
    chk("t2_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t2_req_addr", imem_req_addr, 32'hC);
    tick();

    // Test 3: response arrives while IF/ID is stalled -> HOLD.
    ifid_write = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0D0C_0C33;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("t3_hold_no_req", 32'(imem_req_valid), 32'd0);
    chk("t3_hold_ifid_valid", 32'(ifid_valid), 32'd0);
    tick();
    ifid_write = 1'b1;
    #1;
    chk("t3_hold_no_req2", 32'(imem_req_valid), 32'd0);
    tick();
    #1;
    chk_ifid("t3_release", 1'b1, 32'hC, 32'h0D0C_0C33);
    chk("t3_next_addr", imem_req_addr, 32'h10);

    // Ready low: request must stay pending with a stable address.
    imem_req_ready = 1'b0;
    tick();
    #1;
    chk("rdy_pend_valid", 32'(imem_req_valid), 32'd1);
    chk("rdy_pend_addr", imem_req_addr, 32'h10);
    imem_req_ready = 1'b1;
    tick();

    // Test 4: flush while waiting -> drop the stale response.
    flush = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    chk("t4_flush_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    flush = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    chk("t4_drop_no_req", 32'(imem_req_valid), 32'd0);
    chk_ifid("t4_bubble", 1'b0, 32'hC, NOP);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk_ifid("t4_discard", 1'b0, 32'hC, NOP);
    chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_req_addr", imem_req_addr, 32'h100);
    tick();

    // Test 5: flush coincident with response while IF/ID stalled.
    flush = 1'b1; redirect_pc = 32'h0000_0100; ifid_write = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0100_0033;
    tick();
    flush = 1'b0; ifid_write = 1'b1; imem_rsp_valid = 1'b0;
    #1;
    chk_ifid("t5_bubble", 1'b0, 32'hC, NOP);
    chk("t5_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t5_req_addr", imem_req_addr, 32'h100);
    tick();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0100_0033;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk_ifid("t5_fetch", 1'b1, 32'h100, 32'h0100_0033);
    chk("t5_next_addr", imem_req_addr, 32'h104);
    tick();

    // Test 6: async reset while a request is outstanding.
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk_ifid("t6_rst", 1'b0, 32'h0, NOP);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_refetch_valid", 32'(imem_req_valid), 32'd1);
    chk("t6_refetch_addr", imem_req_addr, 32'h0);
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk("t6_late_ignored", 32'(ifid_valid), 32'd0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0100_0033;
    tick();
    imem_rsp_valid = 1'b0;
    #1;
    chk_ifid("t6_fetch", 1'b1, 32'h0, 32'h0100_0033);
    chk("t6_next_addr", imem_req_addr, 32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
